// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator family:
// FSM state encoding, one-hot result constants and a pair-count helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Result bit order is {lt, gt, eq}
  localparam logic [2:0] RES_EQ = 3'b001;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_LT = 3'b100;

  function automatic int pairs(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/pair_compare_cell.sv
// Combinational 2-bit unsigned compare cell: exactly one of e/g/l is high
// for any x/y pair.
module pair_compare_cell (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       e,
  output logic       g,
  output logic       l
);

  assign e = (x == y);
  assign g = (x[1] & ~y[1]) | ((x[1] ~^ y[1]) & x[0] & ~y[0]);
  assign l = (~x[1] & y[1]) | ((x[1] ~^ y[1]) & ~x[0] & y[0]);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle unsigned magnitude comparator: scans two bits per cycle from the
// MSB end, stops on the first unequal pair, returns a one-hot eq/gt/lt result.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             busy
);

  localparam int NP = pairs(WIDTH);
  localparam int CW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(NP - 1);

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $fatal(1, "serial_magnitude_comparator: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]   cnt;
  logic [2:0]      res;
  logic            pair_e;
  logic            pair_g;
  logic            pair_l;
  logic            accept;
  logic            last_pair;

  assign accept    = start_valid && (state == IDLE);
  assign last_pair = (cnt == '0);

  pair_compare_cell u_cell (
    .x (sa[WIDTH-1 -: 2]),
    .y (sb[WIDTH-1 -: 2]),
    .e (pair_e),
    .g (pair_g),
    .l (pair_l)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = COMPARE;
      COMPARE: if (!pair_e || last_pair) state_next = DONE;
      DONE:    if (done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured once at accept; the shift registers carry the
  // remaining unscanned pairs so later a/b changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      res <= '0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      cnt <= CNT_INIT;
      res <= '0;
    end else if (state == COMPARE) begin
      if (pair_g) begin
        res <= RES_GT;
      end else if (pair_l) begin
        res <= RES_LT;
      end else if (last_pair) begin
        res <= RES_EQ;
      end else begin
        sa  <= sa << 2;
        sb  <= sb << 2;
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign start_ready = (state == IDLE);
  assign busy        = (state == COMPARE);
  assign done_valid  = (state == DONE);
  assign eq          = res[0];
  assign gt          = res[1];
  assign lt          = res[2];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator: directed scenarios plus
// randomized operands against a pair-scan reference model, WIDTH=8 and WIDTH=2.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic       eq, gt, lt, busy;

  logic       start_valid2 = 1'b0;
  logic       start_ready2;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       done_valid2;
  logic       done_ready2 = 1'b0;
  logic       eq2, gt2, lt2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .done_valid(done_valid), .done_ready(done_ready),
    .eq(eq), .gt(gt), .lt(lt), .busy(busy)
  );

  serial_magnitude_comparator #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_valid(start_valid2), .start_ready(start_ready2),
    .a(a2), .b(b2), .done_valid(done_valid2), .done_ready(done_ready2),
    .eq(eq2), .gt(gt2), .lt(lt2), .busy(busy2)
  );

  // Reference model: index (1-based) of the first differing 2-bit group from the MSB
  function automatic int model_lat(input int unsigned av, input int unsigned bv, input int width);
    for (int i = 0; i < width / 2; i++) begin
      if (((av >> (width - 2 - 2 * i)) & 3) != ((bv >> (width - 2 - 2 * i)) & 3))
        return i + 1;
    end
    return width / 2;
  endfunction

  // Reference result as {lt, gt, eq}
  function automatic logic [2:0] model_res(input int unsigned av, input int unsigned bv);
    if (av > bv) return 3'b010;
    if (av < bv) return 3'b100;
    return 3'b001;
  endfunction

  // Drives one operation on the WIDTH=8 instance and reports what it observed
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit release_done,
                      input bit scramble, output int lat, output logic [2:0] res,
                      output int busy_cycles, output bit early_result, output bit timeout);
    int n;
    timeout = 0; early_result = 0; busy_cycles = 0; lat = 0; n = 0;
    a = av; b = bv; done_ready = release_done; start_valid = 1'b1;
    while (!start_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!start_ready) timeout = 1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    if (scramble) begin
      a = 8'hFF; b = 8'h00;
    end
    while (!done_valid && lat < 20) begin
      if (busy) busy_cycles++;
      if (eq | gt | lt) early_result = 1;
      @(posedge clk); #1; lat++;
    end
    if (!done_valid) timeout = 1;
    res = {lt, gt, eq};
    if (release_done) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({eq, gt, lt, done_valid, busy} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000", {eq, gt, lt, done_valid, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_start_ready: got %b expected 1", start_ready);
    end
    checks++;
    if (start_ready2 !== 1'b1 || done_valid2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_w2: got ready=%b valid=%b expected ready=1 valid=0", start_ready2, done_valid2);
    end
  endtask

  task automatic test_equal();
    int lat, bc; logic [2:0] r; bit early, to;
    run8(8'hA5, 8'hA5, 1'b1, 1'b0, lat, r, bc, early, to);
    checks++;
    if (to || lat != 4) begin
      errors++;
      $display("[TB] FAIL equal_latency: got %0d (timeout=%0d) expected 4", lat, to);
    end
    checks++;
    if (r !== 3'b001) begin
      errors++;
      $display("[TB] FAIL equal_result: got %b expected 001", r);
    end
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL equal_return_idle: got ready=%b valid=%b expected ready=1 valid=0", start_ready, done_valid);
    end
  endtask

  task automatic test_gt_first_pair();
    int lat, bc; logic [2:0] r; bit early, to;
    run8(8'h80, 8'h7F, 1'b1, 1'b0, lat, r, bc, early, to);
    checks++;
    if (to || lat != 1) begin
      errors++;
      $display("[TB] FAIL gt_latency: got %0d expected 1", lat);
    end
    checks++;
    if (r !== 3'b010) begin
      errors++;
      $display("[TB] FAIL gt_result: got %b expected 010", r);
    end
    checks++;
    if (bc != 1) begin
      errors++;
      $display("[TB] FAIL gt_busy_cycles: got %0d expected 1", bc);
    end
  endtask

  task automatic test_operand_change();
    int lat, bc; logic [2:0] r; bit early, to;
    run8(8'h12, 8'h13, 1'b1, 1'b1, lat, r, bc, early, to);
    checks++;
    if (to || lat != 4) begin
      errors++;
      $display("[TB] FAIL scramble_latency: got %0d expected 4", lat);
    end
    checks++;
    if (r !== 3'b100) begin
      errors++;
      $display("[TB] FAIL scramble_result: got %b expected 100", r);
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("[TB] FAIL result_zero_during_compare: got %b expected 0", early);
    end
  endtask

  task automatic test_hold_done();
    int lat, bc, lat2; logic [2:0] r; bit early, to;
    run8(8'h9C, 8'h3C, 1'b0, 1'b0, lat, r, bc, early, to);
    checks++;
    if (to || r !== 3'b010) begin
      errors++;
      $display("[TB] FAIL hold_first_result: got %b expected 010", r);
    end
    a = 8'h01; b = 8'h02; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (done_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b0 || {lt, gt, eq} !== 3'b010) begin
        errors++;
        $display("[TB] FAIL hold_stable: got valid=%b ready=%b busy=%b res=%b expected valid=1 ready=0 busy=0 res=010",
                 done_valid, start_ready, busy, {lt, gt, eq});
      end
      @(posedge clk); #1;
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release_idle: got ready=%b valid=%b expected ready=1 valid=0", start_ready, done_valid);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || {lt, gt, eq} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL hold_next_accept: got busy=%b res=%b expected busy=1 res=000", busy, {lt, gt, eq});
    end
    lat2 = 0;
    while (!done_valid && lat2 < 20) begin
      @(posedge clk); #1; lat2++;
    end
    checks++;
    if (lat2 != model_lat(8'h01, 8'h02, 8) || {lt, gt, eq} !== model_res(8'h01, 8'h02)) begin
      errors++;
      $display("[TB] FAIL hold_next_result: got lat=%0d res=%b expected lat=%0d res=%b",
               lat2, {lt, gt, eq}, model_lat(8'h01, 8'h02, 8), model_res(8'h01, 8'h02));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_compare();
    bit seen_valid;
    a = 8'h00; b = 8'h01; done_ready = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre_busy: got %b expected 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({eq, gt, lt, done_valid, busy} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL abort_async_clear: got %b expected 00000", {eq, gt, lt, done_valid, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_valid) seen_valid = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen_valid !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got seen_valid=%b ready=%b expected 0 and 1", seen_valid, start_ready);
    end
  endtask

  task automatic test_random();
    int lat, bc; logic [2:0] r; bit early, to;
    logic [7:0] av, bv;
    for (int i = 0; i < 40; i++) begin
      av = 8'($urandom);
      bv = (i % 4 == 0) ? av : (i % 4 == 1) ? (av ^ 8'(1 << $urandom_range(7, 0))) : 8'($urandom);
      run8(av, bv, 1'b1, 1'b0, lat, r, bc, early, to);
      checks++;
      if (to || lat != model_lat(av, bv, 8) || r !== model_res(av, bv) || early) begin
        errors++;
        $display("[TB] FAIL random a=%h b=%h: got lat=%0d res=%b early=%b expected lat=%0d res=%b early=0",
                 av, bv, lat, r, early, model_lat(av, bv, 8), model_res(av, bv));
      end
    end
  endtask

  task automatic test_width2_exhaustive();
    int lat;
    done_ready2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a2 = 2'(i >> 2); b2 = 2'(i & 3); start_valid2 = 1'b1;
      @(posedge clk); #1;
      start_valid2 = 1'b0;
      lat = 0;
      while (!done_valid2 && lat < 10) begin
        @(posedge clk); #1; lat++;
      end
      checks++;
      if (lat != 1 || {lt2, gt2, eq2} !== model_res(i >> 2, i & 3)) begin
        errors++;
        $display("[TB] FAIL w2 a=%0d b=%0d: got lat=%0d res=%b expected lat=1 res=%b",
                 i >> 2, i & 3, lat, {lt2, gt2, eq2}, model_res(i >> 2, i & 3));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt_first_pair();
    test_operand_change();
    test_hold_done();
    test_reset_mid_compare();
    test_random();
    test_width2_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Multi-cycle unsigned magnitude comparator for WIDTH-bit operands.
- Scans two bits per cycle, MSB pair first, and terminates early on the first unequal pair.
- Each cycle it cascades one 2-bit equal/greater/less evaluation into a running result.
- Sits in the comparator family as the sequential consumer of the 2-bit compare cell.
- Upstream producers hand it operands over a valid/ready handshake. It returns a one-hot eq/gt/lt result over a second valid/ready handshake.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2 (elaboration-time check, fatal otherwise).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_valid  input  1  operands a/b valid.
start_ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
done_valid  output  1  result valid (high only in DONE).
done_ready  input  1  consumer accepts result.
eq  output  1  A == B.
gt  output  1  A > B.
lt  output  1  A < B.
busy  output  1  high in COMPARE.

Behaviour:
Reset (asynchronous, takes effect immediately, any state):
- state=IDLE.
- eq=gt=lt=0, done_valid=0, busy=0.
- Shift registers and pair counter cleared.
- start_ready=1 once in IDLE.

States:
- IDLE: start_ready=1. On start_valid&&start_ready:
  - capture a,b into internal shift regs sa,sb;
  - load pair counter with WIDTH/2-1;
  - clear eq/gt/lt;
  - go to COMPARE.
  - a/b are ignored at all other times; later changes do not affect an in-flight compare.
- COMPARE: each cycle, evaluate pair sa[W-1:W-2] vs sb[W-1:W-2].
  - Pair unequal: set gt or lt from the pair result; go to DONE.
  - Pair equal and counter==0: set eq=1; go to DONE.
  - Otherwise: shift sa,sb left by 2 (zero fill); decrement counter; stay.
- DONE: done_valid=1; eq/gt/lt held stable and exactly one is high.
  - On done_ready: go to IDLE. Results remain readable until the next accept clears them.
  - done_ready while not in DONE is ignored.

Latency and throughput:
- Accept edge to done_valid = k cycles, where k is the 1-based index of the first differing pair from the MSB.
- Equal operands: k = WIDTH/2. WIDTH=8 gives 1..4 cycles.
- Minimum throughput: one compare per k+2 cycles (accept, k compare cycles, handshake). No overlap of two operations.

Output encoding: eq/gt/lt are registered outputs, never combinational from a/b; they are all zero from accept until the result is ready.

Boundary cases:
- WIDTH=2: one compare cycle.
- All-zero and all-one operands: eq after WIDTH/2 cycles.
- Reset asserted mid-COMPARE or in DONE aborts the operation; no done_valid pulse follows.
- start_valid held high in DONE does not pre-accept.

Decomposition:
Shared package cmp_pkg:
- state enum {IDLE, COMPARE, DONE};
- result encoding constants RES_EQ/RES_GT/RES_LT (3-bit one-hot);
- function pairs(width)=width/2.

One natural sub-module, pair_compare_cell (combinational):
- Inputs: 2-bit x, 2-bit y.
- Outputs: e,g,l, with e = both bits equal, g = x1&~y1 | (x1~^y1)&x0&~y0, and l symmetric.
- The top level instantiates one cell on the shift-register heads.

Test Plan:
1. WIDTH=8, a=0xA5, b=0xA5, done_ready=1 -> done_valid rises 4 cycles after accept, eq=1, gt=lt=0; start_ready returns next cycle.
2. a=0x80, b=0x7F -> done_valid 1 cycle after accept, gt=1; busy high for exactly 1 cycle.
3. a=0x12, b=0x13 -> lt=1 after 4 cycles; a driven to 0xFF during COMPARE has no effect on the result.
4. Hold done_ready=0 for 5 cycles in DONE with start_valid=1 -> done_valid, gt/lt/eq stable; start_ready=0; no new capture. Release -> IDLE, then the next operands are accepted.
5. Assert rst 2 cycles into the compare of a=0x00, b=0x01 -> all outputs 0 immediately (asynchronous); no done_valid afterward; start_ready=1 after release.
6. WIDTH=2 build, exhaustive 16 operand pairs back-to-back -> each result one-hot and matching a<b / a==b / a>b, each after 1 cycle.
